// File: rtl/pn_pkg.sv
// Shared definitions for the Polish-notation evaluator, its token driver
// and the bench: mode/operator codes, depths, FSM states, err bit indices.
package pn_pkg;

  localparam int MAX_TOK = 12;
  localparam int MAX_RES = 4;

  typedef enum logic [1:0] {
    PRE_SORT   = 2'd0,
    POST_SORT  = 2'd1,
    PRE_STACK  = 2'd2,
    POST_STACK = 2'd3
  } pn_mode_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_ABS = 3'd3
  } pn_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE
  } pn_state_e;

  localparam int ERR_OVF = 0;
  localparam int ERR_LEN = 1;
  localparam int ERR_OOW = 2;
  localparam int ERR_TMO = 3;

  typedef struct packed {
    logic       op;
    logic [2:0] data;
  } pn_tok_t;

  function automatic logic is_stack(
    input logic [1:0] mode
  );
    return (mode == PRE_STACK) ||
           (mode == POST_STACK);
  endfunction

  // Stack modes reply once; sort modes reply once per token triple.
  function automatic logic [2:0] pn_exp_res(
    input logic [1:0] mode,
    input logic [3:0] cnt
  );
    return is_stack(mode) ? 3'd1
                          : 3'(cnt / 4'd3);
  endfunction

  function automatic logic pn_len_bad(
    input logic [1:0] mode,
    input logic [3:0] cnt
  );
    return (cnt == 4'd0) ||
           (!is_stack(mode) && (cnt % 4'd3) != 4'd0);
  endfunction

endpackage

// File: rtl/pn_rsp_collector.sv
// Captures evaluator replies while the driver waits: result file,
// result count, and the "last expected reply" flag for the FSM.
module pn_rsp_collector
  import pn_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [1:0]  mode_i,
  input  logic [3:0]  cnt_i,
  input  logic        vld_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  idx_i,
  output logic [31:0] rdata_o,
  output logic [2:0]  count_o,
  output logic        cap_o,
  output logic        last_o
);

  logic [31:0] res_q [MAX_RES];
  logic [2:0]  count_q;
  logic [2:0]  count_d;
  logic [2:0]  exp_cnt;

  assign exp_cnt = pn_exp_res(mode_i, cnt_i);
  assign cap_o   = en_i & vld_i;
  assign count_d = count_q + 3'd1;
  assign last_o  = cap_o && (count_d == exp_cnt);
  assign rdata_o = res_q[idx_i];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < MAX_RES; i++)
        res_q[i] <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (cap_o) begin
      res_q[count_q[1:0]] <= data_i;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pn_token_tx.sv
// Host-side token driver for the PN evaluator: buffers tokens, bursts
// them on start, collects replies. Optional watchdog: PN_TX_TIMEOUT_EN.
module pn_token_tx
  import pn_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        wr_operator,
  input  logic [2:0]  wr_data,
  input  logic        start,
  input  logic [1:0]  start_mode,
  output logic        busy,
  output logic        done,
  output logic [3:0]  err,
  output logic [3:0]  tok_count,
  output logic        pn_in_valid,
  output logic [1:0]  pn_mode,
  output logic        pn_operator,
  output logic [2:0]  pn_in,
  input  logic        pn_out_valid,
  input  logic [31:0] pn_out,
  input  logic [1:0]  res_idx,
  output logic [31:0] res_data,
  output logic [2:0]  res_count
);

  localparam logic [3:0] TOK_FULL = 4'(MAX_TOK);

  pn_state_e  state_q, state_d;
  pn_tok_t    buf_q [MAX_TOK];
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] err_q, err_d;
  logic       done_q, done_d;
  logic       vld_q, vld_d;
  logic [1:0] pmode_q, pmode_d;
  pn_tok_t    ptok_q, ptok_d;
  logic       wr_ok, acc, cap, last;

`ifdef PN_TX_TIMEOUT_EN
  localparam logic [10:0] WD_LIM = 11'(TIMEOUT_CYC - 1);
  logic [10:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    err_d   = err_q;
    done_d  = 1'b0;
    vld_d   = 1'b0;
    pmode_d = 2'd0;
    ptok_d  = '0;
    wr_ok   = 1'b0;
    acc     = 1'b0;
`ifdef PN_TX_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (pn_len_bad(start_mode, cnt_q)) begin
            err_d[ERR_LEN] = 1'b1;
            done_d = 1'b1;
          end else begin
            acc     = 1'b1;
            err_d[3:1] = '0;
            mode_d  = start_mode;
            idx_d   = '0;
            vld_d   = 1'b1;
            pmode_d = start_mode;
            ptok_d  = buf_q[0];
            state_d = S_SEND;
          end
        end else if (wr_en) begin
          if (cnt_q == TOK_FULL) begin
            err_d[ERR_OVF] = 1'b1;
          end else begin
            wr_ok = 1'b1;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_SEND: begin
        if (idx_q == cnt_q - 4'd1) begin
          state_d = S_WAIT;
`ifdef PN_TX_TIMEOUT_EN
          wd_d = '0;
`endif
        end else begin
          idx_d  = idx_q + 4'd1;
          vld_d  = 1'b1;
          ptok_d = buf_q[idx_d];
        end
      end
      S_WAIT: begin
        if (last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
`ifdef PN_TX_TIMEOUT_EN
        else if (cap) begin
          wd_d = '0;
        end else if (wd_q == WD_LIM) begin
          err_d[ERR_TMO] = 1'b1;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          wd_d = wd_q + 11'd1;
        end
`endif
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (pn_out_valid && state_q != S_WAIT)
      err_d[ERR_OOW] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mode_q  <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      pmode_q <= '0;
      ptok_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      pmode_q <= pmode_d;
      ptok_q  <= ptok_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_TOK; i++)
        buf_q[i] <= '0;
    end else if (wr_ok) begin
      buf_q[cnt_q] <= '{op: wr_operator, data: wr_data};
    end
  end

`ifdef PN_TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`endif

  pn_rsp_collector u_col (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (acc),
    .en_i    (state_q == S_WAIT),
    .mode_i  (mode_q),
    .cnt_i   (cnt_q),
    .vld_i   (pn_out_valid),
    .data_i  (pn_out),
    .idx_i   (res_idx),
    .rdata_o (res_data),
    .count_o (res_count),
    .cap_o   (cap),
    .last_o  (last)
  );

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign tok_count   = cnt_q;
  assign pn_in_valid = vld_q;
  assign pn_mode     = pmode_q;
  assign pn_operator = ptok_q.op;
  assign pn_in       = ptok_q.data;

endmodule

// File: tb/tb_pn_token_tx.sv
// Self-checking bench for pn_token_tx: table vectors, random transfers
// against a spec-level model, and hand-written corner sequences.
module tb_pn_token_tx;
  import pn_pkg::*;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        wr_en = 0, wr_operator = 0;
  logic [2:0]  wr_data = 0;
  logic        start = 0;
  logic [1:0]  start_mode = 0;
  logic        busy, done;
  logic [3:0]  err, tok_count;
  logic        pn_in_valid, pn_operator;
  logic [1:0]  pn_mode;
  logic [2:0]  pn_in;
  logic        pn_out_valid = 0;
  logic [31:0] pn_out = 0;
  logic [1:0]  res_idx = 0;
  logic [31:0] res_data;
  logic [2:0]  res_count;

  int ntest = 0;
  int nfail = 0;
  logic [3:0] err_m = 0;

  always #5 clk = ~clk;

  pn_token_tx #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_operator(wr_operator),
    .wr_data(wr_data), .start(start),
    .start_mode(start_mode), .busy(busy),
    .done(done), .err(err), .tok_count(tok_count),
    .pn_in_valid(pn_in_valid), .pn_mode(pn_mode),
    .pn_operator(pn_operator), .pn_in(pn_in),
    .pn_out_valid(pn_out_valid), .pn_out(pn_out),
    .res_idx(res_idx), .res_data(res_data),
    .res_count(res_count)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    wr_en = 0; start = 0; pn_out_valid = 0;
    tick();
    rst_n = 1;
    err_m = 0;
  endtask

  task automatic wr(input logic [3:0] t);
    wr_en = 1;
    wr_operator = t[3];
    wr_data = t[2:0];
    tick();
    wr_en = 0;
  endtask

  task automatic send_chk(input string tag,
                          input logic [1:0] m,
                          input logic [3:0] tq[$]);
    logic [5:0] bq[$];
    logic [5:0] e;
    int k = 0;
    while (pn_in_valid && k < 16) begin
      bq.push_back({pn_mode, pn_operator, pn_in});
      k++;
      tick();
    end
    chk({tag, " beats"}, bq.size(), tq.size());
    for (int i = 0; i < bq.size() && i < tq.size(); i++) begin
      e = {(i == 0) ? m : 2'd0, tq[i]};
      chk($sformatf("%s beat%0d", tag, i), bq[i], e);
    end
    chk({tag, " busy"}, busy, 1);
  endtask

  task automatic reply(input string tag, input logic [31:0] v,
                       input bit last, input int cnt);
    pn_out_valid = 1;
    pn_out = v;
    tick();
    pn_out_valid = 0;
    chk({tag, " done"}, done, last);
    chk({tag, " rcnt"}, res_count, cnt);
  endtask

  task automatic xfer(input logic [1:0] m, input int n,
                      input bit rej, input int nres,
                      input string tag);
    logic [3:0]  tq[$];
    logic [31:0] rq[$];
    logic [3:0]  t;
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      t = 4'($urandom);
      wr(t);
      if (tq.size() < MAX_TOK) tq.push_back(t);
      else err_m[ERR_OVF] = 1;
    end
    chk({tag, " cnt"}, tok_count, tq.size());
    start = 1;
    start_mode = m;
    tick();
    start = 0;
    if (rej) begin
      err_m[ERR_LEN] = 1;
      chk({tag, " rej done"}, done, 1);
      chk({tag, " rej vld"}, pn_in_valid, 0);
      chk({tag, " rej busy"}, busy, 0);
      chk({tag, " rej err"}, err, err_m);
      tick();
      chk({tag, " rej done2"}, done, 0);
      chk({tag, " rej vld2"}, pn_in_valid, 0);
      chk({tag, " rej cnt"}, tok_count, tq.size());
      do_reset();
      return;
    end
    err_m[3:1] = 0;
    send_chk(tag, m, tq);
    for (int r = 0; r < nres; r++) begin
      repeat ($urandom_range(0, 2)) tick();
      v = $urandom;
      rq.push_back(v);
      reply($sformatf("%s r%0d", tag, r), v,
            r == nres - 1, r + 1);
    end
    for (int r = 0; r < nres; r++) begin
      res_idx = 2'(r);
      #1;
      chk($sformatf("%s res%0d", tag, r), res_data, rq[r]);
    end
    tick();
    chk({tag, " end done"}, done, 0);
    chk({tag, " end busy"}, busy, 0);
    chk({tag, " end cnt"}, tok_count, 0);
    chk({tag, " end err"}, err, err_m);
  endtask

  typedef struct {
    logic [1:0] mode;
    int         n;
    bit         rej;
    int         nres;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [3:0] tq[$];
    logic [1:0] m;
    int n, nb, nres;
    bit rej;

    tbl[0]  = '{2'd3, 3, 0, 1};
    tbl[1]  = '{2'd2, 1, 0, 1};
    tbl[2]  = '{2'd0, 6, 0, 2};
    tbl[3]  = '{2'd1, 12, 0, 4};
    tbl[4]  = '{2'd1, 5, 1, 0};
    tbl[5]  = '{2'd0, 0, 1, 0};
    tbl[6]  = '{2'd2, 0, 1, 0};
    tbl[7]  = '{2'd0, 9, 0, 3};
    tbl[8]  = '{2'd3, 7, 0, 1};
    tbl[9]  = '{2'd1, 4, 1, 0};
    tbl[10] = '{2'd1, 13, 0, 4};
    tbl[11] = '{2'd2, 12, 0, 1};

    #2;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst cnt", tok_count, 0);
    chk("rst vld", pn_in_valid, 0);
    chk("rst mode", pn_mode, 0);
    chk("rst rcnt", res_count, 0);
    chk("rst res", res_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    tq = '{{1'b0, 3'd3}, {1'b0, 3'd4}, {1'b1, OP_MUL}};
    foreach (tq[i]) wr(tq[i]);
    start = 1; start_mode = 2'd3;
    tick();
    start = 0;
    send_chk("t1", 2'd3, tq);
    wr_en = 1; start = 1;
    tick();
    wr_en = 0; start = 0;
    chk("t1 busy wr cnt", tok_count, 3);
    chk("t1 busy err", err, 0);
    reply("t1", 32'd12, 1, 1);
    res_idx = 0;
    #1;
    chk("t1 res0", res_data, 12);
    tick();
    chk("t1 idle cnt", tok_count, 0);

    tq = '{{1'b1, OP_ADD}, {1'b0, 3'd2}, {1'b0, 3'd5},
           {1'b1, OP_SUB}, {1'b0, 3'd1}, {1'b0, 3'd2}};
    foreach (tq[i]) wr(tq[i]);
    start = 1; start_mode = 2'd0;
    tick();
    start = 0;
    send_chk("t2", 2'd0, tq);
    reply("t2a", 32'd7, 0, 1);
    tick();
    chk("t2 gap done", done, 0);
    reply("t2b", 32'hffff_ffff, 1, 2);
    res_idx = 1;
    #1;
    chk("t2 res1", res_data, 32'hffff_ffff);
    tick();

    tq = '{4'h1, 4'h2, 4'h3};
    foreach (tq[i]) wr(tq[i]);
    start = 1; start_mode = 2'd1;
    wr_en = 1; wr_data = 3'd7;
    tick();
    start = 0; wr_en = 0;
    send_chk("sw", 2'd1, tq);
    chk("sw err", err, 0);
    reply("sw", 32'd5, 1, 1);
    tick();

    pn_out_valid = 1;
    tick();
    pn_out_valid = 0;
    chk("oow err", err, 4'b0100);
    chk("oow rcnt", res_count, 1);
    do_reset();

    foreach (tbl[i])
      xfer(tbl[i].mode, tbl[i].n, tbl[i].rej,
           tbl[i].nres, $sformatf("tbl%0d", i));

    for (int it = 0; it < 25; it++) begin
      m = 2'($urandom_range(0, 3));
      n = $urandom_range(0, 13);
      nb = (n > MAX_TOK) ? MAX_TOK : n;
      rej = (nb == 0) || (m < 2 && nb % 3 != 0);
      nres = (m >= 2) ? 1 : nb / 3;
      xfer(m, n, rej, nres, $sformatf("rnd%0d", it));
    end
    do_reset();

    for (int i = 0; i < 6; i++) wr(4'(i));
    start = 1; start_mode = 2'd0;
    tick();
    start = 0;
    tick();
    tick();
    chk("mr beat2 vld", pn_in_valid, 1);
    chk("mr beat2 in", pn_in, 2);
    #2;
    rst_n = 0;
    #1;
    chk("mr vld", pn_in_valid, 0);
    chk("mr cnt", tok_count, 0);
    chk("mr busy", busy, 0);
    tick();
    rst_n = 1;
    err_m = 0;
    xfer(2'd3, 3, 0, 1, "post-rst");

`ifdef PN_TX_TIMEOUT_EN
    tq = '{4'h1, 4'h2, 4'h3};
    foreach (tq[i]) wr(tq[i]);
    start = 1; start_mode = 2'd2;
    tick();
    start = 0;
    send_chk("tmo", 2'd2, tq);
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("tmo c%0d", c), done, c == 16);
    end
    chk("tmo err", err, 4'b1000);
    chk("tmo rcnt", res_count, 0);
    tick();
    chk("tmo idle", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
